instruction_decode: RTL and testbench

Decode stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch. Realigns the fetch-stage `pc_next` with the instruction word returned by the synchronous instruction SRAM one cycle later. Decodes the word, reads two operands from the architectural register file and registers everything into the ID/EX pipeline registers. Branch/jump flush from EX invalidates in-flight instructions.

---
 rtl/mips_pkg.sv | 139 +++++++++++++
 rtl/instruction_decode_register_file.sv | 40 ++++
 rtl/instruction_decode.sv | 106 ++++++++++
 tb/tb_instruction_decode.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, ALU operation enum,
// ID/EX control-bit positions and the combinational instruction decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_LUI = 4'd7
  } alu_op_t;

  localparam int CTRL_W          = 9;
  localparam int CTRL_REG_WRITE  = 8;
  localparam int CTRL_MEM_READ   = 7;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_DST    = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_BRANCH_NE  = 1;
  localparam int CTRL_JUMP       = 0;

  // Bits that must never fire for an unsupported encoding.
  localparam logic [CTRL_W-1:0] CTRL_KILL_MASK = (CTRL_W'(1) << CTRL_REG_WRITE)
                                               | (CTRL_W'(1) << CTRL_MEM_WRITE)
                                               | (CTRL_W'(1) << CTRL_BRANCH)
                                               | (CTRL_W'(1) << CTRL_JUMP);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    alu_op_t           alu_op;
    logic [31:0]       imm;
    logic [4:0]        rd;
    logic              link;
    logic              illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] funct;
    op        = instr[31:26];
    funct     = instr[5:0];
    d.ctrl    = '0;
    d.alu_op  = ALU_ADD;
    d.imm     = {{16{instr[15]}}, instr[15:0]};
    d.rd      = instr[15:11];
    d.link    = 1'b0;
    d.illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        d.ctrl[CTRL_REG_DST]   = 1'b1;
        d.ctrl[CTRL_REG_WRITE] = 1'b1;
        case (funct)
          FN_ADD:  d.alu_op = ALU_ADD;
          FN_SUB:  d.alu_op = ALU_SUB;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_SLT:  d.alu_op = ALU_SLT;
          FN_SLL:  d.alu_op = ALU_SLL;
          FN_SRL:  d.alu_op = ALU_SRL;
          FN_JR: begin
            d.ctrl[CTRL_REG_WRITE] = 1'b0;
            d.ctrl[CTRL_JUMP]      = 1'b1;
          end
          default: d.illegal = 1'b1;
        endcase
      end
      OP_ADDI: d.ctrl = CTRL_W'(9'h110);
      OP_SLTI: begin
        d.ctrl   = CTRL_W'(9'h110);
        d.alu_op = ALU_SLT;
      end
      OP_ANDI: begin
        d.ctrl   = CTRL_W'(9'h110);
        d.alu_op = ALU_AND;
        d.imm    = {16'h0000, instr[15:0]};
      end
      OP_ORI: begin
        d.ctrl   = CTRL_W'(9'h110);
        d.alu_op = ALU_OR;
        d.imm    = {16'h0000, instr[15:0]};
      end
      OP_LUI: begin
        d.ctrl   = CTRL_W'(9'h110);
        d.alu_op = ALU_LUI;
        d.imm    = {instr[15:0], 16'h0000};
      end
      OP_LW: d.ctrl = CTRL_W'(9'h1B0);
      OP_SW: d.ctrl = CTRL_W'(9'h050);
      OP_BEQ: begin
        d.ctrl[CTRL_BRANCH] = 1'b1;
        d.alu_op            = ALU_SUB;
      end
      OP_BNE: begin
        d.ctrl[CTRL_BRANCH]    = 1'b1;
        d.ctrl[CTRL_BRANCH_NE] = 1'b1;
        d.alu_op               = ALU_SUB;
      end
      OP_J: d.ctrl[CTRL_JUMP] = 1'b1;
      OP_JAL: begin
        d.ctrl[CTRL_JUMP]      = 1'b1;
        d.ctrl[CTRL_REG_WRITE] = 1'b1;
        d.link                 = 1'b1;
        d.rd                   = 5'd31;  // link register is the implicit destination
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) d.ctrl = d.ctrl & ~CTRL_KILL_MASK;
    return d;
  endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 architectural register file, two combinational read ports, one write port.
// ID_WB_BYPASS_EN: forward same-cycle write data to a matching read port.
module register_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];
  logic        wr_live;

  assign wr_live = wen && (waddr != 5'd0);

  // NOTE: the whole array sits on the async reset because the pipeline relies on
  // every register reading 0 after reset; this forces flops rather than an SRAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[waddr] <= wdata;
    end
  end

  // NOTE: every output gets a value before any condition, so no latch can form.
  always_comb begin
    rdata_a = (ra == 5'd0) ? 32'h0 : regs[ra];
    rdata_b = (rb == 5'd0) ? 32'h0 : regs[rb];
`ifdef ID_WB_BYPASS_EN
    if (wr_live && (waddr == ra)) rdata_a = wdata;
    if (wr_live && (waddr == rb)) rdata_b = wdata;
`endif
  end

endmodule

// File: rtl/instruction_decode.sv
// MIPS decode stage: realigns fetch PC with SRAM data, decodes, reads operands
// and registers the ID/EX slot. ID_WB_BYPASS_EN enables write-back forwarding.
module instruction_decode
  import mips_pkg::*;
#(
  parameter int IM_AW = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  input  logic        im_cen,
  input  logic [31:0] im_dataout,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [31:0] id_pc_next,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data,
  output logic [31:0] id_imm,
  output logic [25:0] id_jtarget,
  output logic [3:0]  id_alu_op,
  output logic [8:0]  id_ctrl,
  output logic        id_link,
  output logic        id_illegal
);

  // An out-of-range SRAM address width leaves the stage permanently idle.
  localparam bit IM_AW_OK = (IM_AW > 0) && (IM_AW <= 30);

  logic        a_v;
  logic [31:0] a_pc;
  logic        load_v;
  dec_t        dec;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v  <= 1'b0;
      a_pc <= '0;
    end else begin
      a_v  <= ~im_cen & ~flush & IM_AW_OK;
      a_pc <= pc_next;
    end
  end

  register_file u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra      (im_dataout[25:21]),
    .rb      (im_dataout[20:16]),
    .rdata_a (rs_data),
    .rdata_b (rt_data),
    .wen     (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  always_comb dec = decode(im_dataout);

  assign load_v = a_v & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid   <= 1'b0;
      id_pc_next <= '0;
      id_rs      <= '0;
      id_rt      <= '0;
      id_rd      <= '0;
      id_shamt   <= '0;
      id_rs_data <= '0;
      id_rt_data <= '0;
      id_imm     <= '0;
      id_jtarget <= '0;
      id_alu_op  <= '0;
      id_ctrl    <= '0;
      id_link    <= 1'b0;
      id_illegal <= 1'b0;
    end else begin
      id_valid   <= load_v;
      id_pc_next <= a_pc;
      id_rs      <= im_dataout[25:21];
      id_rt      <= im_dataout[20:16];
      id_rd      <= dec.rd;
      id_shamt   <= im_dataout[10:6];
      id_rs_data <= rs_data;
      id_rt_data <= rt_data;
      id_imm     <= dec.imm;
      id_jtarget <= im_dataout[25:0];
      id_alu_op  <= dec.alu_op;
      // A dead slot must carry no side effects downstream.
      id_ctrl    <= load_v ? dec.ctrl : '0;
      id_link    <= load_v & dec.link;
      id_illegal <= load_v & dec.illegal;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed scoreboard bench for instruction_decode: expectations are queued at
// fetch issue and compared when the slot is due in ID/EX.
`timescale 1ns/1ps
module tb_instruction_decode;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_next = '0;
  logic        im_cen = 1'b1;
  logic [31:0] im_dataout = '0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        id_valid;
  logic [31:0] id_pc_next;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [25:0] id_jtarget;
  logic [3:0]  id_alu_op;
  logic [8:0]  id_ctrl;
  logic        id_link, id_illegal;

  instruction_decode #(.IM_AW(11)) dut (
    .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .im_cen(im_cen),
    .im_dataout(im_dataout), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .id_valid(id_valid), .id_pc_next(id_pc_next),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_jtarget(id_jtarget), .id_alu_op(id_alu_op), .id_ctrl(id_ctrl),
    .id_link(id_link), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          due;
    logic [31:0] pc;
    logic [8:0]  ctrl;
    logic [8:0]  mask;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] rtd;
    logic [25:0] jt;
    logic        link;
    logic        ill;
    logic [4:0]  chk;
  } exp_t;

  localparam logic [4:0] K_IMM = 5'b00001;
  localparam logic [4:0] K_RD  = 5'b00010;
  localparam logic [4:0] K_RT  = 5'b00100;
  localparam logic [4:0] K_JT  = 5'b01000;
  localparam logic [4:0] K_ALU = 5'b10000;

`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] SAME_CYCLE_RT = 32'hDEADBEEF;
`else
  localparam logic [31:0] SAME_CYCLE_RT = 32'h0000_0000;
`endif

  localparam logic [31:0] I_ADD  = 32'h0022_1820;  // add $3,$1,$2
  localparam logic [31:0] I_ADDI = 32'h2004_FFFB;  // addi $4,$0,-5
  localparam logic [31:0] I_ORI  = 32'h3406_8000;  // ori $6,$0,0x8000
  localparam logic [31:0] I_LUI  = 32'h3C07_1234;  // lui $7,0x1234
  localparam logic [31:0] I_SW5  = 32'hAC05_0000;  // sw $5,0($0)
  localparam logic [31:0] I_SW0  = 32'hAC00_0000;  // sw $0,0($0)
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;  // opcode 0x3F
  localparam logic [31:0] I_BADR = 32'h0000_003F;  // R-type funct 0x3F
  localparam logic [31:0] I_JAL  = 32'h0EAB_CDEF;  // jal 0x2ABCDEF
  localparam logic [31:0] I_BEQ  = 32'h1022_0004;
  localparam logic [31:0] I_BNE  = 32'h1422_0004;
  localparam logic [31:0] I_LW   = 32'h8C09_0004;  // lw $9,4($0)
  localparam logic [31:0] I_ANDI = 32'h300A_8001;  // andi $10,$0,0x8001

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        q[$];
  logic [31:0] pend_instr = '0;
  exp_t        none = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [8:0] ctrl, input logic [8:0] mask,
                              input logic [3:0] alu, input logic [31:0] imm, input logic [4:0] rd,
                              input logic [31:0] rtd, input logic [25:0] jt, input logic link,
                              input logic ill, input logic [4:0] chk);
    exp_t e;
    e = '{due: 0, pc: pc, ctrl: ctrl, mask: mask, alu: alu, imm: imm, rd: rd,
          rtd: rtd, jt: jt, link: link, ill: ill, chk: chk};
    return e;
  endfunction

  // One clock: drive fetch/SRAM/WB inputs, queue the issued slot, check ID/EX.
  task automatic cycle(input logic cen, input logic [31:0] pc, input logic [31:0] instr,
                       input exp_t e, input logic fl, input logic wen,
                       input logic [4:0] wa, input logic [31:0] wd);
    exp_t x;
    @(negedge clk);
    im_cen     = cen;
    pc_next    = pc;
    im_dataout = pend_instr;
    flush      = fl;
    wb_en      = wen;
    wb_addr    = wa;
    wb_data    = wd;
    if (fl && q.size() != 0 && q[$].due == cyc + 1) void'(q.pop_back());
    if (!cen && !fl) begin
      x     = e;
      x.due = cyc + 2;
      q.push_back(x);
    end
    pend_instr = instr;
    @(posedge clk);
    cyc++;
    #1;
    if (q.size() != 0 && q[0].due == cyc) begin
      x = q.pop_front();
      check($sformatf("valid@pc%0d", x.pc), 32'(id_valid), 32'd1);
      check($sformatf("pc_next@pc%0d", x.pc), id_pc_next, x.pc);
      check($sformatf("ctrl@pc%0d", x.pc), 32'(id_ctrl & x.mask), 32'(x.ctrl));
      check($sformatf("link@pc%0d", x.pc), 32'(id_link), 32'(x.link));
      check($sformatf("illegal@pc%0d", x.pc), 32'(id_illegal), 32'(x.ill));
      if ((x.chk & K_IMM) != 0) check($sformatf("imm@pc%0d", x.pc), id_imm, x.imm);
      if ((x.chk & K_RD) != 0)  check($sformatf("rd@pc%0d", x.pc), 32'(id_rd), 32'(x.rd));
      if ((x.chk & K_RT) != 0)  check($sformatf("rt_data@pc%0d", x.pc), id_rt_data, x.rtd);
      if ((x.chk & K_JT) != 0)  check($sformatf("jtarget@pc%0d", x.pc), 32'(id_jtarget), 32'(x.jt));
      if ((x.chk & K_ALU) != 0) check($sformatf("alu_op@pc%0d", x.pc), 32'(id_alu_op), 32'(x.alu));
    end else begin
      check($sformatf("bubble_valid@cyc%0d", cyc), 32'(id_valid), 32'd0);
      check($sformatf("bubble_ctrl@cyc%0d", cyc), 32'(id_ctrl), 32'd0);
      check($sformatf("bubble_link@cyc%0d", cyc), 32'(id_link), 32'd0);
      check($sformatf("bubble_illegal@cyc%0d", cyc), 32'(id_illegal), 32'd0);
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] instr, input exp_t e);
    cycle(1'b0, pc, instr, e, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic idle();
    cycle(1'b1, 32'd0, 32'd0, none, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    // Reset state, sampled between edges.
    #12;
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_pc_next", id_pc_next, 32'd0);
    check("rst_ctrl", 32'(id_ctrl), 32'd0);
    check("rst_imm", id_imm, 32'd0);
    check("rst_rs_data", id_rs_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1,  I_ADD,  mk(1,  9'h108, 9'h1FF, ALU_ADD, 0, 5'd3, 0, 0, 0, 0, K_RD | K_ALU));
    issue(2,  I_ADDI, mk(2,  9'h110, 9'h1FF, ALU_ADD, 32'hFFFF_FFFB, 0, 0, 0, 0, 0, K_IMM | K_ALU));
    issue(3,  I_ORI,  mk(3,  9'h110, 9'h1FF, ALU_OR,  32'h0000_8000, 0, 0, 0, 0, 0, K_IMM | K_ALU));
    issue(4,  I_LUI,  mk(4,  9'h110, 9'h1FF, ALU_LUI, 32'h1234_0000, 0, 0, 0, 0, 0, K_IMM | K_ALU));
    issue(5,  I_SW5,  mk(5,  9'h050, 9'h1FF, ALU_ADD, 0, 0, SAME_CYCLE_RT, 0, 0, 0, K_IMM | K_RT | K_ALU));
    // Write $5 while sw $5 at pc5 is decoding.
    cycle(1'b0, 6, I_SW5, mk(6, 9'h050, 9'h1FF, ALU_ADD, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, K_RT),
          1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    issue(7,  I_SW0,  mk(7,  9'h050, 9'h1FF, ALU_ADD, 0, 0, 0, 0, 0, 0, K_RT));
    // Write to $0 while sw $0 at pc7 is decoding: never visible.
    cycle(1'b0, 8, I_SW0, mk(8, 9'h050, 9'h1FF, ALU_ADD, 0, 0, 0, 0, 0, 0, K_RT),
          1'b0, 1'b1, 5'd0, 32'h1234_5678);
    issue(9,  I_BAD,  mk(9,  9'h000, 9'h145, ALU_ADD, 0, 0, 0, 0, 0, 1, 5'b0));
    issue(10, I_BADR, mk(10, 9'h000, 9'h145, ALU_ADD, 0, 0, 0, 0, 0, 1, 5'b0));
    issue(11, I_JAL,  mk(11, 9'h001, 9'h001, ALU_ADD, 0, 0, 0, 26'h2AB_CDEF, 1, 0, K_JT));
    issue(12, I_BEQ,  mk(12, 9'h004, 9'h1FF, ALU_SUB, 0, 0, 0, 0, 0, 0, K_ALU));
    idle();
    issue(13, I_BNE,  mk(13, 9'h006, 9'h1FF, ALU_SUB, 0, 0, 0, 0, 0, 0, K_ALU));
    issue(14, I_LW,   mk(14, 9'h1B0, 9'h1FF, ALU_ADD, 32'd4, 0, 0, 0, 0, 0, K_IMM | K_ALU));
    issue(15, I_ANDI, mk(15, 9'h110, 9'h1FF, ALU_AND, 32'h0000_8001, 0, 0, 0, 0, 0, K_IMM | K_ALU));
    issue(16, I_ADD,  mk(16, 9'h108, 9'h1FF, ALU_ADD, 0, 5'd3, 0, 0, 0, 0, K_RD));
    // Flush kills pc16 (decoding) and pc17 (being aligned): two bubbles follow.
    cycle(1'b0, 17, I_ADD, none, 1'b1, 1'b0, 5'd0, 32'd0);
    issue(20, I_ADDI, mk(20, 9'h110, 9'h1FF, ALU_ADD, 32'hFFFF_FFFB, 0, 0, 0, 0, 0, K_IMM));
    issue(21, I_ORI,  mk(21, 9'h110, 9'h1FF, ALU_OR,  32'h0000_8000, 0, 0, 0, 0, 0, K_IMM));
    idle();
    idle();
    check("drain_1", 32'(q.size()), 32'd0);

    // Asynchronous reset mid-stream.
    issue(30, I_ADD,  mk(30, 9'h108, 9'h1FF, ALU_ADD, 0, 5'd3, 0, 0, 0, 0, K_RD));
    issue(31, I_ADDI, mk(31, 9'h110, 9'h1FF, ALU_ADD, 32'hFFFF_FFFB, 0, 0, 0, 0, 0, K_IMM));
    issue(32, I_SW5,  mk(32, 9'h050, 9'h1FF, ALU_ADD, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, K_RT));
    #2;
    rst_n  = 1'b0;
    im_cen = 1'b1;
    #1;
    check("async_rst_valid", 32'(id_valid), 32'd0);
    check("async_rst_pc_next", id_pc_next, 32'd0);
    check("async_rst_imm", id_imm, 32'd0);
    check("async_rst_ctrl", 32'(id_ctrl), 32'd0);
    q.delete();
    pend_instr = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Registers were cleared by reset: $5 reads 0 again.
    issue(40, I_SW5,  mk(40, 9'h050, 9'h1FF, ALU_ADD, 0, 0, 32'd0, 0, 0, 0, K_RT));
    issue(41, I_LUI,  mk(41, 9'h110, 9'h1FF, ALU_LUI, 32'h1234_0000, 0, 0, 0, 0, 0, K_IMM | K_ALU));
    idle();
    idle();
    check("drain_2", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
